mem_access_req: RTL and testbench

//  MEM-stage data-memory request unit; the issuing end of the load/store path whose writeback end sign/zero-extends rdata.

---
 rtl/mem_access_req.sv | 110 +++++++++++
 tb/tb_mem_access_req.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_req.sv
// mem_access_req: MEM-stage data-memory request unit driving an SRAM-like req/addr_ok/data_ok port.
//   EX side  : ex_valid/ex_ready handshake, ex_is_store, ex_sz, ex_addr, ex_wdata, flush
//   SRAM side: data_sram_req/wr/size/addr/wstrb/wdata out; addr_ok, data_ok, rdata in
//   WB side  : wb_valid/wb_ready handshake, wb_rdata (right-aligned), wb_sz, wb_ale, wb_badv
module mem_access_req #(
    parameter int ADDR_W    = 32,
    parameter bit ALE_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_is_store,
    input  logic [1:0]        ex_sz,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic              flush,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [3:0]        data_sram_wstrb,
    output logic [31:0]       data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [31:0]       wb_rdata,
    output logic [1:0]        wb_sz,
    output logic              wb_ale,
    output logic [ADDR_W-1:0] wb_badv
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, DROP} state_t;
    state_t state, state_nx;
    logic              is_store, ale, flushed, accept, mis, cap;
    logic [1:0]        sz, lo;
    logic [ADDR_W-1:0] addr, a_eff;
    logic [3:0]        wstrb;
    logic [31:0]       wdata, rdata_q;

    assign accept = ex_valid & ex_ready & ~flush;
    assign mis    = (ex_sz == 2'b01 & ex_addr[0]) | (ex_sz == 2'b10 & ex_addr[1:0] != 2'b00);
    // Low address bits aligned to the access size; used when misalignment is not trapped.
    assign lo     = ex_sz == 2'b00 ? ex_addr[1:0] : ex_sz == 2'b01 ? {ex_addr[1], 1'b0} : 2'b00;
    // A trapped misaligned op keeps its raw address so it can be reported as badv.
    assign a_eff  = (ALE_CHECK && mis) ? ex_addr : {ex_addr[ADDR_W-1:2], lo};
    // Data is captured on every path that lands in DONE from the memory side.
    assign cap    = state_nx == DONE && (state == ADDR || state == DATA);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (ALE_CHECK && mis) ? DONE : ADDR;
            // A flush while req is held cannot retract the request; the response is swallowed instead.
            ADDR: if (data_sram_addr_ok) state_nx = (flush | flushed) ? (data_sram_data_ok ? IDLE : DROP)
                                                                     : (data_sram_data_ok ? DONE : DATA);
            DATA: state_nx = flush ? (data_sram_data_ok ? IDLE : DROP) : (data_sram_data_ok ? DONE : DATA);
            DROP: if (data_sram_data_ok) state_nx = IDLE;
            DONE: if (flush | wb_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            is_store <= 1'b0;
            sz       <= 2'b00;
            addr     <= '0;
            wstrb    <= 4'b0000;
            wdata    <= 32'd0;
            ale      <= 1'b0;
            flushed  <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            if (accept) begin
                is_store <= ex_is_store;
                sz       <= ex_sz;
                addr     <= a_eff;
                wstrb    <= !ex_is_store ? 4'b0000 : ex_sz == 2'b00 ? 4'b0001 << lo
                          : ex_sz == 2'b01 ? 4'b0011 << {lo[1], 1'b0} : 4'b1111;
                wdata    <= ex_sz == 2'b00 ? {4{ex_wdata[7:0]}} : ex_sz == 2'b01 ? {2{ex_wdata[15:0]}} : ex_wdata;
                ale      <= ALE_CHECK && mis;
                flushed  <= 1'b0;
                rdata_q  <= 32'd0;
            end else if (state == ADDR && flush) begin
                flushed  <= 1'b1;
            end
            if (cap) rdata_q <= is_store ? 32'd0 : data_sram_rdata >> {addr[1:0], 3'b000};
        end
    end

    assign ex_ready        = state == IDLE;
    assign data_sram_req   = state == ADDR;
    assign data_sram_wr    = is_store;
    assign data_sram_size  = sz;
    assign data_sram_addr  = addr;
    assign data_sram_wstrb = wstrb;
    assign data_sram_wdata = wdata;
    assign wb_valid        = state == DONE;
    assign wb_rdata        = rdata_q;
    assign wb_sz           = sz;
    assign wb_ale          = ale & (state == DONE);
    assign wb_badv         = addr;
endmodule

// File: tb/tb_mem_access_req.sv
// tb_mem_access_req: self-checking bench for mem_access_req (vector table, hand sequences, random vs model).
module tb_mem_access_req;
    logic        clk = 1'b0;
    logic        resetn, ex_valid, ex_ready, ex_is_store, flush;
    logic [1:0]  ex_sz;
    logic [31:0] ex_addr, ex_wdata;
    logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic [3:0]  data_sram_wstrb;
    logic        wb_valid, wb_ready, wb_ale;
    logic [31:0] wb_rdata, wb_badv;
    logic [1:0]  wb_sz;
    int checks = 0;
    int errors = 0;

    mem_access_req #(.ADDR_W(32), .ALE_CHECK(1'b1)) dut (
        .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_store(ex_is_store), .ex_sz(ex_sz), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .flush(flush), .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rdata(wb_rdata), .wb_sz(wb_sz), .wb_ale(wb_ale), .wb_badv(wb_badv)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic [31:0] a, wd, rd;
        int          ao, dl;
        logic [3:0]  strb;
        logic [31:0] ewd, erd;
        logic        ale;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: derived from byte counts and offsets rather than lane tables.
    function automatic logic m_ale(input logic [1:0] sz, input logic [31:0] a);
        int n, off;
        n = 1 << sz;
        off = int'(a % 4);
        return (off % n) != 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic st, input logic [1:0] sz, input logic [31:0] a);
        int n, off;
        n = 1 << sz;
        off = int'(a % 4);
        return st ? 4'(((1 << n) - 1) << off) : 4'd0;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        int n;
        n = 1 << sz;
        r = 32'd0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rd(input logic st, input logic [31:0] a, input logic [31:0] rd);
        int off;
        off = int'(a % 4);
        return st ? 32'd0 : rd >> (8 * off);
    endfunction

    task automatic run_op(input logic st, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int ao, input int dl, input logic [3:0] e_strb,
                          input logic [31:0] e_wd, input logic [31:0] e_rd, input logic e_ale, input logic hold);
        logic [31:0] m;
        m = sz == 2'd2 ? 32'hFFFF_FFFF : sz == 2'd1 ? 32'h0000_FFFF : 32'h0000_00FF;
        chk("ex_ready_idle", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; ex_is_store = st; ex_sz = sz; ex_addr = a; ex_wdata = wd;
        step();
        ex_valid = 1'b0; ex_is_store = ~st; ex_sz = 2'($urandom_range(0, 2)); ex_addr = $urandom; ex_wdata = $urandom;
        if (e_ale) begin
            chk("ale_no_req", 32'(data_sram_req), 32'd0);
            chk("ale_wb_valid", 32'(wb_valid), 32'd1);
            chk("ale_flag", 32'(wb_ale), 32'd1);
            chk("ale_badv", wb_badv, a);
            chk("ale_wb_sz", 32'(wb_sz), 32'(sz));
        end else begin
            for (int i = 0; i <= ao; i++) begin
                chk("req", 32'(data_sram_req), 32'd1);
                chk("wr", 32'(data_sram_wr), 32'(st));
                chk("size", 32'(data_sram_size), 32'(sz));
                chk("addr", data_sram_addr, a);
                chk("wstrb", 32'(data_sram_wstrb), 32'(e_strb));
                if (st) chk("wdata", data_sram_wdata, e_wd);
                chk("no_wb_in_addr", 32'(wb_valid), 32'd0);
                if (i < ao) step();
            end
            data_sram_addr_ok = 1'b1;
            if (dl == 0) begin data_sram_data_ok = 1'b1; data_sram_rdata = rd; end
            step();
            data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
            if (dl > 0) begin
                for (int i = 1; i < dl; i++) begin
                    chk("no_early_wb", 32'(wb_valid), 32'd0);
                    chk("req_dropped", 32'(data_sram_req), 32'd0);
                    step();
                end
                chk("no_early_wb", 32'(wb_valid), 32'd0);
                data_sram_data_ok = 1'b1; data_sram_rdata = rd;
                step();
                data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
            end
            chk("wb_valid", 32'(wb_valid), 32'd1);
            chk("wb_ale_clear", 32'(wb_ale), 32'd0);
            chk("wb_sz", 32'(wb_sz), 32'(sz));
            chk("wb_rdata", wb_rdata & m, e_rd & m);
        end
        if (hold) begin
            step();
            chk("wb_hold", 32'(wb_valid), 32'd1);
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("wb_retire", 32'(wb_valid), 32'd0);
        chk("ex_ready_after", 32'(ex_ready), 32'd1);
    endtask

    initial begin
        int acc, wbs, reqs;
        logic st;
        logic [1:0] sz;
        logic [31:0] a, wd, rd;
        resetn = 1'b0; ex_valid = 1'b0; ex_is_store = 1'b0; ex_sz = 2'd0; ex_addr = 32'd0; ex_wdata = 32'd0;
        flush = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0; wb_ready = 1'b0;
        #2;
        chk("rst_req", 32'(data_sram_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_ale", 32'(wb_ale), 32'd0);
        chk("rst_wstrb", 32'(data_sram_wstrb), 32'd0);
        chk("rst_wb_rdata", wb_rdata, 32'd0);
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        step(); step();
        resetn = 1'b1;
        step();

        tbl[0] = '{1'b0, 2'd0, 32'h1003, 32'h0, 32'h80AABBCC, 0, 0, 4'b0000, 32'h0, 32'h80, 1'b0};
        tbl[1] = '{1'b1, 2'd1, 32'h2002, 32'h1234, 32'h0, 3, 1, 4'b1100, 32'h12341234, 32'h0, 1'b0};
        tbl[2] = '{1'b0, 2'd2, 32'h3001, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 1'b1};
        tbl[3] = '{1'b1, 2'd0, 32'h5001, 32'hAB, 32'h0, 1, 0, 4'b0010, 32'hABABABAB, 32'h0, 1'b0};
        tbl[4] = '{1'b0, 2'd1, 32'h6002, 32'h0, 32'hDEADBEEF, 0, 2, 4'b0000, 32'h0, 32'hDEAD, 1'b0};
        tbl[5] = '{1'b1, 2'd2, 32'h7000, 32'hCAFEF00D, 32'h0, 2, 0, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0};
        tbl[6] = '{1'b0, 2'd1, 32'h6001, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 1'b1};
        tbl[7] = '{1'b1, 2'd2, 32'h7002, 32'h55, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 1'b1};
        foreach (tbl[i])
            run_op(tbl[i].st, tbl[i].sz, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].ao, tbl[i].dl,
                   tbl[i].strb, tbl[i].ewd, tbl[i].erd, tbl[i].ale, i[0]);

        // Flush during ADDR: request stays up until addr_ok, then the response is swallowed.
        ex_valid = 1'b1; ex_is_store = 1'b0; ex_sz = 2'd2; ex_addr = 32'h4000;
        step();
        ex_valid = 1'b0;
        chk("fl_req", 32'(data_sram_req), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_req_held", 32'(data_sram_req), 32'd1);
        chk("fl_addr_held", data_sram_addr, 32'h4000);
        step();
        chk("fl_req_held2", 32'(data_sram_req), 32'd1);
        data_sram_addr_ok = 1'b1;
        step();
        data_sram_addr_ok = 1'b0;
        chk("fl_req_gone", 32'(data_sram_req), 32'd0);
        chk("fl_no_wb", 32'(wb_valid), 32'd0);
        chk("fl_busy", 32'(ex_ready), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_busy_drop", 32'(ex_ready), 32'd0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h12345678;
        step();
        data_sram_data_ok = 1'b0;
        chk("fl_no_wb_after", 32'(wb_valid), 32'd0);
        chk("fl_ready_after", 32'(ex_ready), 32'd1);

        // Flush coinciding with ex_valid: nothing accepted.
        ex_valid = 1'b1; flush = 1'b1;
        step();
        ex_valid = 1'b0; flush = 1'b0;
        chk("flacc_no_req", 32'(data_sram_req), 32'd0);
        chk("flacc_ready", 32'(ex_ready), 32'd1);

        // Flush while holding a result in DONE.
        ex_valid = 1'b1; ex_is_store = 1'b0; ex_sz = 2'd2; ex_addr = 32'h9000;
        step();
        ex_valid = 1'b0; data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hA5A5A5A5;
        step();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
        chk("done_wb", 32'(wb_valid), 32'd1);
        chk("done_rdata", wb_rdata, 32'hA5A5A5A5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("done_flush_wb", 32'(wb_valid), 32'd0);
        chk("done_flush_ready", 32'(ex_ready), 32'd1);

        // Back-to-back st.w with same-cycle addr_ok/data_ok and wb_ready held high.
        acc = 0; wbs = 0; reqs = 0;
        ex_valid = 1'b1; ex_is_store = 1'b1; ex_sz = 2'd2; ex_addr = 32'h100; ex_wdata = 32'h11;
        data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; wb_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            acc += int'(ex_valid & ex_ready);
            wbs += int'(wb_valid);
            reqs += int'(data_sram_req);
            step();
        end
        ex_valid = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; wb_ready = 1'b0;
        chk("b2b_accepts", 32'(acc), 32'd4);
        chk("b2b_completions", 32'(wbs), 32'd4);
        chk("b2b_reqs", 32'(reqs), 32'd4);
        step();
        chk("b2b_idle", 32'(ex_ready), 32'd1);

        // Reset while in ADDR drops req at once.
        ex_valid = 1'b1; ex_is_store = 1'b0; ex_sz = 2'd2; ex_addr = 32'hB000;
        step();
        ex_valid = 1'b0;
        chk("ra_req", 32'(data_sram_req), 32'd1);
        resetn = 1'b0;
        #1;
        chk("ra_req_async", 32'(data_sram_req), 32'd0);
        step();
        resetn = 1'b1;
        step();

        // Reset while in DATA, then a stale data_ok must be ignored.
        ex_valid = 1'b1; ex_is_store = 1'b0; ex_sz = 2'd2; ex_addr = 32'h8000;
        step();
        ex_valid = 1'b0; data_sram_addr_ok = 1'b1;
        step();
        data_sram_addr_ok = 1'b0;
        chk("rd_busy", 32'(ex_ready), 32'd0);
        resetn = 1'b0;
        #1;
        chk("rd_req", 32'(data_sram_req), 32'd0);
        chk("rd_wb", 32'(wb_valid), 32'd0);
        chk("rd_ready", 32'(ex_ready), 32'd1);
        step();
        resetn = 1'b1;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFFFFFFFF;
        step();
        data_sram_data_ok = 1'b0;
        chk("stale_no_wb", 32'(wb_valid), 32'd0);
        chk("stale_ready", 32'(ex_ready), 32'd1);
        chk("stale_no_req", 32'(data_sram_req), 32'd0);

        // Random operations against the reference model.
        for (int k = 0; k < 40; k++) begin
            st = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) a = a & ~32'((1 << sz) - 1);
            wd = $urandom;
            rd = $urandom;
            run_op(st, sz, a, wd, rd, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   m_strb(st, sz, a), m_wd(sz, wd), m_rd(st, a, rd), m_ale(sz, a), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
